uart_loader: RTL and testbench
==============================

# uart_loader

Byte-stream command decoder that sits directly downstream of the UART receive FIFO and upstream of its transmit FIFO. It pops received bytes, recognises host commands, assembles 32-bit big-endian words, and writes them sequentially into instruction memory. It also issues a one-cycle run pulse to the MIPS core and returns one ACK/NAK byte per command through the UART transmit FIFO.

## Interface
- `DATA_BITS`, 8: UART byte width.
- `WORD_WIDTH`, 32: instruction-memory word width; must be `4*DATA_BITS`.
- `ADDR_WIDTH`, 10: instruction-memory word-address width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_empty`  in  1  UART RX FIFO empty.
- `r_data`  in  DATA_BITS  head of RX FIFO, valid while `rx_empty`=0.
- `rd_uart`  out  1  pop RX FIFO head this cycle.
- `tx_full`  in  1  UART TX FIFO full.
- `wr_uart`  out  1  push `w_data` into TX FIFO this cycle.
- `w_data`  out  DATA_BITS  response byte.
- `mem_wr_en`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  word address.
- `mem_data`  out  WORD_WIDTH  word to write.
- `run`  out  1  one-cycle start pulse to the core.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Commands: `CMD_LOAD` 0x4C ('L'), `CMD_RUN` 0x52 ('R'). Responses: `ACK` 0x06, `NAK` 0x15.
- States:
  - IDLE: consume 1 byte. LOAD goes to LEN_HI. RUN goes to RUN_P. Any other byte goes to RESP with NAK.
  - LEN_HI, LEN_LO: consume the 16-bit word count N, MSB first. If N=0 after LEN_LO, go to RESP with ACK. Otherwise clear the address and byte counter and go to DATA.
  - DATA: consume bytes MSB first into the word shift register. The 4th byte goes to WRITE.
  - WRITE: assert `mem_wr_en` for one cycle, increment `mem_addr`, decrement the remaining count. When the count reaches 0, go to RESP with ACK; otherwise return to DATA.
  - RUN_P: assert `run` for one cycle, then go to RESP with ACK.
  - RESP: wait for `tx_full`=0, assert `wr_uart` for one cycle, then return to IDLE.
- "Consume" means `rd_uart` = (state is a consuming state) and not `rx_empty`, combinationally. The byte is sampled on that same edge. The state stalls indefinitely while `rx_empty`=1.
- The address is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. N greater than the depth overwrites from address 0 and is not an error.
- The count is 16-bit unsigned. The byte counter is 2 bits and wraps naturally.

## Timing
- Reset values: `rd_uart`=0, `wr_uart`=0, `w_data`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_data`=0, `run`=0, `busy`=0, state IDLE.
- All outputs except `rd_uart` are registered.
- With the RX FIFO continuously non-empty, the loader accepts one byte per cycle. Each word therefore takes 4 consume cycles plus 1 WRITE cycle.
- `mem_wr_en` is high in the cycle after the 4th byte is accepted. `mem_addr` and `mem_data` are stable in that cycle.
- The response byte is pushed at the earliest in the cycle after the last WRITE or RUN_P cycle. It is held in RESP while `tx_full`=1. `w_data` is valid in the same cycle as `wr_uart`.
- `rd_uart` and `wr_uart` are never asserted in RESP, WRITE or RUN_P.
- Reset asserted mid-load: the FSM returns to IDLE immediately. Memory already written is not rolled back. No response is sent.
- Bytes arriving while in RESP stay in the FIFO and are consumed as the next command.

## Structure
- Shared header/package `uart_loader_pkg`: command and response constants, and the state encoding (7 states, 3 bits).
- One sub-module: `uart_word_packer`.
  - Inputs: load strobe, byte, clear.
  - Holds the 2-bit byte counter and the WORD_WIDTH shift register.
  - Flags `word_done` on the 4th byte.
- The FSM, address/count registers and output registers stay in `uart_loader`.

## Test plan
- Reset, then idle with `rx_empty`=1: all outputs 0, `busy`=0, no `rd_uart`.
- Stream 4C 00 02 12 34 56 78 9A BC DE F0:
  - writes 0x12345678 at address 0 and 0x9ABCDEF0 at address 1, each with a one-cycle `mem_wr_en`;
  - then exactly one `wr_uart` with 0x06.
- Stream 52: one `run` pulse, then `w_data`=0x06. Stream 0x41: no `run`, no write, `w_data`=0x15.
- LOAD with N=0 (4C 00 00): no `mem_wr_en`, ACK 0x06.
- LOAD with N=1, `tx_full` held high for 20 cycles after the last byte:
  - `wr_uart` stays low for those 20 cycles, then pulses once;
  - bytes queued meanwhile are processed afterwards.
- Interrupting traffic:
  - Gaps with `rx_empty`=1 between data bytes leave the result unchanged.
  - Reset after 2 of 4 data bytes: IDLE, `mem_addr`=0, and a following 52 gives `run` plus ACK.
  - LOAD with N=1025 at ADDR_WIDTH=10: the last word lands at address 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encoding for the UART instruction loader.
package uart_loader_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RUN_P  = 3'd5,
        ST_RESP   = 3'd6
    } state_e;

    // States that pop a byte from the RX FIFO whenever one is available.
    function automatic logic is_consuming(input state_e s);
        logic r;
        case (s)
            ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Packs bytes MSB first into a word; flags the byte that completes a word.
module uart_word_packer
    import uart_loader_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_BITS-1:0]  data_i,
    input  logic                  clear_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_done_o
);

    logic [1:0]            cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;

    // Next byte count and shift-register contents.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (load_i) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[WORD_WIDTH-DATA_BITS-1:0], data_i};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and shift-register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = load_i && (cnt_q == 2'd3);

endmodule

// File: rtl/uart_loader.sv
// UART command decoder: loads big-endian words into instruction memory,
// pulses run, and answers every command with one ACK/NAK byte.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_empty,
    input  logic [DATA_BITS-1:0]  r_data,
    output logic                  rd_uart,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [DATA_BITS-1:0]  w_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  run,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0]  w_data_q, w_data_d;
    logic                  wr_uart_q, mem_wr_en_q, run_q, busy_q;
    logic                  rd_s, load_s, clear_s, word_done_s;

    assign rd_s   = is_consuming(state_q) && !rx_empty;
    assign load_s = (state_q == ST_DATA) && !rx_empty;

    uart_word_packer #(
        .DATA_BITS  (DATA_BITS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_s),
        .data_i      (r_data),
        .clear_i     (clear_s),
        .word_o      (mem_data),
        .word_done_o (word_done_s)
    );

    // Next-state, count, address and response-code logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        w_data_d = w_data_q;
        clear_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_s) begin
                    if (r_data == DATA_BITS'(CMD_LOAD)) begin
                        state_d = ST_LEN_HI;
                    end else if (r_data == DATA_BITS'(CMD_RUN)) begin
                        state_d = ST_RUN_P;
                    end else begin
                        state_d  = ST_RESP;
                        w_data_d = DATA_BITS'(RSP_NAK);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN_HI: begin
                if (rd_s) begin
                    count_d = {r_data, count_q[7:0]};
                    state_d = ST_LEN_LO;
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (rd_s) begin
                    count_d = {count_q[15:8], r_data};
                    if (count_d == 16'd0) begin
                        state_d  = ST_RESP;
                        w_data_d = DATA_BITS'(RSP_ACK);
                    end else begin
                        clear_s = 1'b1;
                        addr_d  = '0;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (word_done_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                // Address wraps naturally; oversized loads overwrite from 0.
                addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                count_d = count_q - 16'd1;
                if (count_q == 16'd1) begin
                    state_d  = ST_RESP;
                    w_data_d = DATA_BITS'(RSP_ACK);
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RUN_P: begin
                state_d  = ST_RESP;
                w_data_d = DATA_BITS'(RSP_ACK);
            end
            ST_RESP: begin
                if (!tx_full) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= 16'd0;
            addr_q      <= '0;
            w_data_q    <= '0;
            wr_uart_q   <= 1'b0;
            mem_wr_en_q <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            w_data_q    <= w_data_d;
            wr_uart_q   <= (state_q == ST_RESP) && !tx_full;
            mem_wr_en_q <= (state_d == ST_WRITE);
            run_q       <= (state_d == ST_RUN_P);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign rd_uart   = rd_s;
    assign wr_uart   = wr_uart_q;
    assign w_data    = w_data_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = addr_q;
    assign run       = run_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader with a queue-modelled RX FIFO.
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        run;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int runs  = 0;
    int rds   = 0;

    logic [7:0]  rxq[$];
    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [7:0]  rsp[$];

    uart_loader #(.DATA_BITS(8), .WORD_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .run       (run),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One clock: present FIFO head at negedge, log outputs, pop on posedge.
    task automatic cycle();
        logic pop;
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
        #1;
        pop = rd_uart;
        if (mem_wr_en) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wc.push_back(cyc);
        end
        if (wr_uart) rsp.push_back(w_data);
        if (run) runs++;
        if (rd_uart) rds++;
        @(posedge clk);
        if (pop) void'(rxq.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); rsp.delete();
        runs = 0; rds = 0;
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({rd_uart, wr_uart, w_data, mem_wr_en, mem_addr, mem_data, run, busy} !== 55'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rd=%b wr=%b wd=%h we=%b a=%h d=%h run=%b busy=%b required all 0",
                     rd_uart, wr_uart, w_data, mem_wr_en, mem_addr, mem_data, run, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        cycles(5);
        n_cmp++;
        if (rds !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: got rd_count=%0d busy=%b required 0/0", rds, busy);
        end
    endtask

    task automatic test_load_two();
        logic [7:0] s[11];
        s = '{8'h4C, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        clear_logs();
        foreach (s[i]) push(s[i]);
        cycles(25);
        n_cmp++;
        if (wa.size() !== 2) begin
            n_err++;
            $display("FAIL load2_count: got %0d writes required 2", wa.size());
        end else begin
            n_cmp++;
            if (wa[0] !== 10'd0 || wd[0] !== 32'h12345678) begin
                n_err++;
                $display("FAIL load2_w0: got %h@%h required 12345678@000", wd[0], wa[0]);
            end
            n_cmp++;
            if (wa[1] !== 10'd1 || wd[1] !== 32'h9ABCDEF0) begin
                n_err++;
                $display("FAIL load2_w1: got %h@%h required 9abcdef0@001", wd[1], wa[1]);
            end
            n_cmp++;
            if (wc[1] - wc[0] !== 5) begin
                n_err++;
                $display("FAIL load2_spacing: got %0d cycles required 5", wc[1] - wc[0]);
            end
        end
        n_cmp++;
        if (rsp.size() !== 1 || rsp[0] !== 8'h06) begin
            n_err++;
            $display("FAIL load2_resp: got %0d bytes first %h required 1 byte 06",
                     rsp.size(), (rsp.size() != 0) ? rsp[0] : 8'hxx);
        end
    endtask

    task automatic test_run_and_bad();
        clear_logs();
        push(8'h52);
        cycles(8);
        n_cmp++;
        if (runs !== 1 || rsp.size() !== 1 || rsp[0] !== 8'h06 || wa.size() !== 0) begin
            n_err++;
            $display("FAIL run_cmd: got runs=%0d resp=%0d writes=%0d required 1/1(06)/0",
                     runs, rsp.size(), wa.size());
        end
        clear_logs();
        push(8'h41);
        cycles(8);
        n_cmp++;
        if (runs !== 0 || rsp.size() !== 1 || rsp[0] !== 8'h15 || wa.size() !== 0) begin
            n_err++;
            $display("FAIL bad_cmd: got runs=%0d resp=%0d writes=%0d required 0/1(15)/0",
                     runs, rsp.size(), wa.size());
        end
    endtask

    task automatic test_len_zero();
        clear_logs();
        push(8'h4C); push(8'h00); push(8'h00);
        cycles(10);
        n_cmp++;
        if (wa.size() !== 0 || rsp.size() !== 1 || rsp[0] !== 8'h06) begin
            n_err++;
            $display("FAIL len_zero: got writes=%0d resp=%0d required 0 writes, one 06",
                     wa.size(), rsp.size());
        end
    endtask

    task automatic test_tx_full();
        clear_logs();
        tx_full = 1'b1;
        push(8'h4C); push(8'h00); push(8'h01);
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        push(8'h52);
        cycles(30);
        n_cmp++;
        if (rsp.size() !== 0 || runs !== 0) begin
            n_err++;
            $display("FAIL txfull_hold: got resp=%0d runs=%0d required 0/0", rsp.size(), runs);
        end
        n_cmp++;
        if (wa.size() !== 1 || wd[0] !== 32'hA1B2C3D4) begin
            n_err++;
            $display("FAIL txfull_write: got %0d writes required one of a1b2c3d4", wa.size());
        end
        tx_full = 1'b0;
        cycles(15);
        n_cmp++;
        if (rsp.size() !== 2 || runs !== 1) begin
            n_err++;
            $display("FAIL txfull_release: got resp=%0d runs=%0d required 2/1", rsp.size(), runs);
        end else begin
            n_cmp++;
            if (rsp[0] !== 8'h06 || rsp[1] !== 8'h06) begin
                n_err++;
                $display("FAIL txfull_bytes: got %h %h required 06 06", rsp[0], rsp[1]);
            end
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        push(8'h4C); push(8'h00); push(8'h01);
        cycles(5);
        push(8'h11); cycles(3);
        push(8'h22); cycles(4);
        push(8'h33); cycles(2);
        push(8'h44); cycles(10);
        n_cmp++;
        if (wa.size() !== 1 || wa[0] !== 10'd0 || wd[0] !== 32'h11223344 ||
            rsp.size() !== 1 || rsp[0] !== 8'h06) begin
            n_err++;
            $display("FAIL gaps: got writes=%0d resp=%0d required one 11223344@0 and 06",
                     wa.size(), rsp.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        push(8'h4C); push(8'h00); push(8'h01); push(8'hAA); push(8'hBB);
        cycles(7);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mem_addr !== 10'd0 || mem_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: got busy=%b addr=%h we=%b required 0/000/0",
                     busy, mem_addr, mem_wr_en);
        end
        @(negedge clk);
        cycles(2);
        reset = 1'b1;
        push(8'h52);
        cycles(10);
        n_cmp++;
        if (wa.size() !== 0 || runs !== 1 || rsp.size() !== 1 || rsp[0] !== 8'h06) begin
            n_err++;
            $display("FAIL midreset_run: got writes=%0d runs=%0d resp=%0d required 0/1/one 06",
                     wa.size(), runs, rsp.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        clear_logs();
        push(8'h4C); push(8'h04); push(8'h01);
        for (int i = 0; i < 1025; i++) begin
            w = 32'hC0DE0000 + i;
            push(w[31:24]); push(w[23:16]); push(w[15:8]); push(w[7:0]);
        end
        cycles(1025 * 5 + 20);
        n_cmp++;
        if (wa.size() !== 1025) begin
            n_err++;
            $display("FAIL wrap_count: got %0d writes required 1025", wa.size());
        end else begin
            n_cmp++;
            if (wa[1023] !== 10'h3FF || wd[1023] !== 32'hC0DE03FF) begin
                n_err++;
                $display("FAIL wrap_top: got %h@%h required c0de03ff@3ff", wd[1023], wa[1023]);
            end
            n_cmp++;
            if (wa[1024] !== 10'h000 || wd[1024] !== 32'hC0DE0400) begin
                n_err++;
                $display("FAIL wrap_last: got %h@%h required c0de0400@000", wd[1024], wa[1024]);
            end
        end
        n_cmp++;
        if (rsp.size() !== 1 || rsp[0] !== 8'h06) begin
            n_err++;
            $display("FAIL wrap_resp: got %0d bytes required one 06", rsp.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_two();
        test_run_and_bad();
        test_len_zero();
        test_tx_full();
        test_gaps();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
